mem_stage: RTL and testbench

- Pipeline stage that consumes the registered outputs of the execute stage.
- Performs LD/ST against an internal byte-wide data memory and produces a register writeback.
- Turns JMP results into a PC redirect pulse and latches HALT.
- Sits between execute and the register file / fetch unit, and back-pressures execute with `stall` while a load is in flight.

---
 rtl/mem_stage_if.sv | 26 ++
 rtl/mem_stage.sv | 134 +++++++++++++
 tb/tb_mem_stage.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Execute-to-memory-stage bus: execute outputs in, stall back, writeback/redirect/halt out.
interface mem_stage_if;
    logic       ex_valid;
    logic [7:0] ex_instr;
    logic [7:0] ex_alu_result;
    logic [7:0] ex_write_data;
    logic [7:0] ex_pc_alu;
    logic       stall;
    logic       wb_valid;
    logic       wb_we;
    logic [1:0] wb_rd;
    logic [7:0] wb_data;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       halted;

    modport master (
        output ex_valid, ex_instr, ex_alu_result, ex_write_data, ex_pc_alu,
        input  stall, wb_valid, wb_we, wb_rd, wb_data, redirect_valid, redirect_pc, halted
    );

    modport slave (
        input  ex_valid, ex_instr, ex_alu_result, ex_write_data, ex_pc_alu,
        output stall, wb_valid, wb_we, wb_rd, wb_data, redirect_valid, redirect_pc, halted
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: LD/ST on an internal byte memory, register writeback, JMP redirect, sticky HALT.
// Optional MEM_CLEAR_ON_RESET_EN: zero the data memory with a one-byte-per-cycle sweep after reset.
module mem_stage #(
    parameter int ADDR_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_stage_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

`ifdef MEM_CLEAR_ON_RESET_EN
    typedef enum logic [1:0] {IDLE, LOAD_WAIT, HALTED, CLEAR} state_t;
    localparam state_t RST_STATE = CLEAR;
`else
    typedef enum logic [1:0] {IDLE, LOAD_WAIT, HALTED} state_t;
    localparam state_t RST_STATE = IDLE;
`endif

    state_t state_q, state_d;

    logic [7:0]        mem [DEPTH];
    logic [7:0]        rd_data;
    logic [1:0]        ld_rd;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        op, sub, rt;
    logic              accept, is_alu, is_st, is_ld, is_jmp, is_halt;

    logic       wb_valid, wb_we, redirect_valid, halted;
    logic [1:0] wb_rd;
    logic [7:0] wb_data, redirect_pc;

`ifdef MEM_CLEAR_ON_RESET_EN
    logic [ADDR_W-1:0] clr_addr;
`endif

    // Funct bits and address bits above the memory depth do not affect this stage.
    logic unused_bits;
    assign unused_bits = ^{bus.ex_instr[1:0], bus.ex_alu_result[7:ADDR_W]};

    assign op   = bus.ex_instr[7:6];
    assign sub  = bus.ex_instr[5:4];
    assign rt   = bus.ex_instr[3:2];
    assign addr = bus.ex_alu_result[ADDR_W-1:0];

    assign is_alu  = (op == 2'b00) || (op == 2'b01 && (sub == 2'b00 || sub == 2'b11));
    assign is_ld   = (op == 2'b01) && (sub == 2'b01);
    assign is_st   = (op == 2'b01) && (sub == 2'b10);
    assign is_jmp  = (op == 2'b10);
    assign is_halt = (op == 2'b11);

    assign bus.stall = (state_q != IDLE);
    assign accept    = bus.ex_valid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && is_ld)   state_d = LOAD_WAIT;
                if (accept && is_halt) state_d = HALTED;
            end
            LOAD_WAIT: state_d = IDLE;
            HALTED:    state_d = HALTED;
`ifdef MEM_CLEAR_ON_RESET_EN
            CLEAR:     if (clr_addr == ADDR_W'(DEPTH - 1)) state_d = IDLE;
`endif
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RST_STATE;
            wb_valid       <= 1'b0;
            wb_we          <= 1'b0;
            wb_rd          <= 2'd0;
            wb_data        <= 8'd0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 8'd0;
            halted         <= 1'b0;
            ld_rd          <= 2'd0;
`ifdef MEM_CLEAR_ON_RESET_EN
            clr_addr       <= '0;
`endif
        end else begin
            state_q        <= state_d;
            wb_valid       <= 1'b0;
            wb_we          <= 1'b0;
            redirect_valid <= 1'b0;
            if (accept) begin
                if (is_alu) begin
                    wb_valid <= 1'b1;
                    wb_we    <= 1'b1;
                    wb_rd    <= rt;
                    wb_data  <= bus.ex_alu_result;
                end
                if (is_st || is_jmp || is_halt) wb_valid <= 1'b1;
                if (is_ld) ld_rd <= rt;
                if (is_jmp) begin
                    redirect_valid <= 1'b1;
                    redirect_pc    <= bus.ex_pc_alu;
                end
                if (is_halt) halted <= 1'b1;
            end else if (state_q == LOAD_WAIT) begin
                // Load data was registered at the accept edge; retire it now.
                wb_valid <= 1'b1;
                wb_we    <= 1'b1;
                wb_rd    <= ld_rd;
                wb_data  <= rd_data;
            end
`ifdef MEM_CLEAR_ON_RESET_EN
            if (state_q == CLEAR) clr_addr <= clr_addr + 1'b1;
`endif
        end
    end

    // Memory array carries no reset; the optional sweep zeroes it instead.
    always_ff @(posedge clk) begin
`ifdef MEM_CLEAR_ON_RESET_EN
        if (state_q == CLEAR) mem[clr_addr] <= 8'd0;
        else
`endif
        if (accept && is_st) mem[addr] <= bus.ex_write_data;
        if (accept && is_ld) rd_data <= mem[addr];
    end

    assign bus.wb_valid       = wb_valid;
    assign bus.wb_we          = wb_we;
    assign bus.wb_rd          = wb_rd;
    assign bus.wb_data        = wb_data;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc;
    assign bus.halted         = halted;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU/ST/LD/JMP/HALT, stall back-pressure, reset abort.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_stage_if bus();
    mem_stage #(.ADDR_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic set_in(input logic [7:0] instr, input logic [7:0] alu,
                          input logic [7:0] wd, input logic [7:0] pc);
        bus.ex_valid      = 1'b1;
        bus.ex_instr      = instr;
        bus.ex_alu_result = alu;
        bus.ex_write_data = wd;
        bus.ex_pc_alu     = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset at a negedge, release on the next negedge, then let any clear sweep finish.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`ifdef MEM_CLEAR_ON_RESET_EN
        for (int n = 0; n < 200 && bus.stall; n++) tick();
`endif
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data, bus.redirect_valid,
             bus.redirect_pc, bus.halted} !== 21'd0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=0", {bus.wb_valid, bus.wb_we,
                bus.wb_rd, bus.wb_data, bus.redirect_valid, bus.redirect_pc, bus.halted});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
`ifdef MEM_CLEAR_ON_RESET_EN
        checks++;
        if (bus.stall !== 1'b1) begin errors++; $display("FAIL reset_stall got=%b exp=1", bus.stall); end
        for (int n = 0; n < 200 && bus.stall; n++) tick();
`else
        checks++;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
`endif
    endtask

    task automatic test_rtype();
        set_in(8'h0C, 8'h5A, 8'h00, 8'h00);
        tick();
        bus.ex_valid = 1'b0;
        checks++;
        if ({bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data} !== {1'b1, 1'b1, 2'd3, 8'h5A}) begin
            errors++; $display("FAIL rtype_wb got=%b%b %0d %h exp=11 3 5a",
                bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data);
        end
        checks++;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL rtype_stall got=%b exp=0", bus.stall); end
        tick();
        checks++;
        if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rtype_pulse got=%b exp=0", bus.wb_valid); end
    endtask

    task automatic test_st_ld();
        set_in(8'h60, 8'h45, 8'hC3, 8'h00);
        tick();
        checks++;
        if ({bus.wb_valid, bus.wb_we} !== 2'b10) begin
            errors++; $display("FAIL st_wb got=%b%b exp=10", bus.wb_valid, bus.wb_we);
        end
        set_in(8'h58, 8'h05, 8'h00, 8'h00);
        tick();
        bus.ex_valid = 1'b0;
        checks++;
        if ({bus.stall, bus.wb_valid} !== 2'b10) begin
            errors++; $display("FAIL ld_stall got=%b%b exp=10", bus.stall, bus.wb_valid);
        end
        tick();
        checks++;
        if ({bus.stall, bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data} !== {3'b011, 2'd2, 8'hC3}) begin
            errors++; $display("FAIL ld_wb got=%b%b%b %0d %h exp=011 2 c3",
                bus.stall, bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data);
        end
        tick();
        checks++;
        if ({bus.stall, bus.wb_valid} !== 2'b00) begin
            errors++; $display("FAIL ld_done got=%b%b exp=00", bus.stall, bus.wb_valid);
        end
    endtask

    task automatic test_back_to_back();
        set_in(8'h60, 8'h21, 8'h9E, 8'h00);
        tick();
        set_in(8'h58, 8'h21, 8'h00, 8'h00);
        tick();
        set_in(8'h44, 8'h33, 8'h00, 8'h00);   // ADDI rt=1 held through the stall
        checks++;
        if ({bus.stall, bus.wb_valid} !== 2'b10) begin
            errors++; $display("FAIL b2b_stall got=%b%b exp=10", bus.stall, bus.wb_valid);
        end
        tick();
        checks++;
        if ({bus.stall, bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data} !== {3'b011, 2'd2, 8'h9E}) begin
            errors++; $display("FAIL b2b_ld got=%b%b%b %0d %h exp=011 2 9e",
                bus.stall, bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data);
        end
        tick();
        bus.ex_valid = 1'b0;
        checks++;
        if ({bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data} !== {2'b11, 2'd1, 8'h33}) begin
            errors++; $display("FAIL b2b_addi got=%b%b %0d %h exp=11 1 33",
                bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data);
        end
        tick();
        checks++;
        if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_dup got=%b exp=0", bus.wb_valid); end
    endtask

    task automatic test_jmp();
        set_in(8'h80, 8'h00, 8'h00, 8'h2A);
        tick();
        bus.ex_valid = 1'b0;
        checks++;
        if ({bus.redirect_valid, bus.redirect_pc, bus.wb_valid, bus.wb_we} !== {1'b1, 8'h2A, 2'b10}) begin
            errors++; $display("FAIL jmp got=%b %h %b%b exp=1 2a 10",
                bus.redirect_valid, bus.redirect_pc, bus.wb_valid, bus.wb_we);
        end
        tick();
        checks++;
        if ({bus.redirect_valid, bus.redirect_pc} !== {1'b0, 8'h2A}) begin
            errors++; $display("FAIL jmp_pulse got=%b %h exp=0 2a", bus.redirect_valid, bus.redirect_pc);
        end
    endtask

    task automatic test_halt();
        set_in(8'h60, 8'h10, 8'h77, 8'h00);
        tick();
        set_in(8'hC0, 8'h00, 8'h00, 8'h00);
        tick();
        checks++;
        if ({bus.halted, bus.stall, bus.wb_valid, bus.wb_we} !== 4'b1110) begin
            errors++; $display("FAIL halt got=%b%b%b%b exp=1110", bus.halted, bus.stall, bus.wb_valid, bus.wb_we);
        end
        set_in(8'h60, 8'h10, 8'hEE, 8'h00);
        repeat (3) tick();
        bus.ex_valid = 1'b0;
        checks++;
        if ({bus.halted, bus.stall, bus.wb_valid} !== 3'b110) begin
            errors++; $display("FAIL halt_hold got=%b%b%b exp=110", bus.halted, bus.stall, bus.wb_valid);
        end
        do_reset();
        checks++;
        if ({bus.halted, bus.stall} !== 2'b00) begin
            errors++; $display("FAIL halt_clear got=%b%b exp=00", bus.halted, bus.stall);
        end
        set_in(8'h58, 8'h10, 8'h00, 8'h00);
        tick();
        bus.ex_valid = 1'b0;
        tick();
        checks++;
`ifdef MEM_CLEAR_ON_RESET_EN
        if (bus.wb_data !== 8'h00) begin errors++; $display("FAIL halt_ld got=%h exp=00", bus.wb_data); end
`else
        if (bus.wb_data !== 8'h77) begin errors++; $display("FAIL halt_ld got=%h exp=77", bus.wb_data); end
`endif
    endtask

    task automatic test_reset_abort();
        int n;
        set_in(8'h5C, 8'h05, 8'h00, 8'h00);
        tick();
        bus.ex_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data, bus.redirect_valid,
             bus.redirect_pc, bus.halted} !== 21'd0) begin
            errors++; $display("FAIL abort_outputs got=%h exp=0", {bus.wb_valid, bus.wb_we,
                bus.wb_rd, bus.wb_data, bus.redirect_valid, bus.redirect_pc, bus.halted});
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 200 && bus.stall; i++) begin
            tick();
            n++;
            if (bus.wb_valid !== 1'b0) begin
                errors++; $display("FAIL abort_wb got=%b exp=0", bus.wb_valid);
            end
        end
        checks++;
`ifdef MEM_CLEAR_ON_RESET_EN
        if (n !== 64) begin errors++; $display("FAIL clear_cycles got=%0d exp=64", n); end
`else
        if (n !== 0) begin errors++; $display("FAIL abort_stall got=%0d exp=0", n); end
`endif
        tick();
        checks++;
        if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL abort_wb got=%b exp=0", bus.wb_valid); end
`ifdef MEM_CLEAR_ON_RESET_EN
        set_in(8'h58, 8'h05, 8'h00, 8'h00);
        tick();
        bus.ex_valid = 1'b0;
        tick();
        checks++;
        if ({bus.wb_valid, bus.wb_data} !== 9'h100) begin
            errors++; $display("FAIL clear_ld got=%b %h exp=1 00", bus.wb_valid, bus.wb_data);
        end
`endif
    endtask

    initial begin
        bus.ex_valid      = 1'b0;
        bus.ex_instr      = 8'h00;
        bus.ex_alu_result = 8'h00;
        bus.ex_write_data = 8'h00;
        bus.ex_pc_alu     = 8'h00;
        test_reset();
        test_rtype();
        test_st_ld();
        test_back_to_back();
        test_jmp();
        test_halt();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
